// File: rtl/branch_resolve_if.sv
// Handshake, resolution-result and prediction-lookup signals for the branch_resolve stage.
// The master side drives execute beats and fetch lookups. The slave side is the resolve stage.
interface branch_resolve_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_imm;
   logic [31:0] in_rs1;
   logic [1:0]  in_kind;
   logic        in_pred_taken;
   logic        cmp_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_link;
   logic        out_misaligned;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] lookup_pc;
   logic        lookup_taken;

   modport master (
      output in_valid, in_pc, in_imm, in_rs1, in_kind, in_pred_taken, cmp_result,
      output out_ready, lookup_pc,
      input  in_ready, out_valid, out_link, out_misaligned, redirect, redirect_pc,
      input  lookup_taken
   );

   modport slave (
      input  in_valid, in_pc, in_imm, in_rs1, in_kind, in_pred_taken, cmp_result,
      input  out_ready, lookup_pc,
      output in_ready, out_valid, out_link, out_misaligned, redirect, redirect_pc,
      output lookup_taken
   );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: resolves the taken/target decision, pulses redirect on mispredict.
// Defining BRANCH_RESOLVE_BHT_EN adds a 2-bit-counter branch history table for fetch lookups.
module branch_resolve #(
   parameter int unsigned BHT_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            reset,
   branch_resolve_if.slave br
);

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_BR   = 2'b01;
   localparam logic [1:0] KIND_JAL  = 2'b10;
   localparam logic [1:0] KIND_JALR = 2'b11;

   logic        out_valid_q;
   logic [31:0] out_link_q;
   logic        out_misaligned_q;
   logic        redirect_q;
   logic [31:0] redirect_pc_q;

   logic        accept;
   logic        resolve;
   logic [31:0] link;
   logic [31:0] pc_target;
   logic [31:0] jalr_sum;
   logic [31:0] target;
   logic        taken;
   logic        mispredict;
   logic        misaligned;
   logic        redirect_d;

   assign br.in_ready = !out_valid_q || br.out_ready || redirect_q;
   assign accept      = br.in_valid && br.in_ready;
   // A beat accepted while redirect is high came from the wrong path and is dropped.
   assign resolve     = accept && !redirect_q;

   assign link      = br.in_pc + 32'd4;
   assign pc_target = br.in_pc + br.in_imm;
   assign jalr_sum  = br.in_rs1 + br.in_imm;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      taken      = 1'b0;
      mispredict = 1'b0;
      target     = link;
      case (br.in_kind)
         KIND_BR: begin
            taken      = br.cmp_result;
            mispredict = br.cmp_result != br.in_pred_taken;
            if (br.cmp_result) target = pc_target;
         end
         KIND_JAL: begin
            taken      = 1'b1;
            mispredict = 1'b1;
            target     = pc_target;
         end
         KIND_JALR: begin
            taken      = 1'b1;
            mispredict = 1'b1;
            target     = {jalr_sum[31:1], 1'b0};
         end
         default: ;
      endcase
      misaligned = taken && target[1];
      redirect_d = mispredict && !misaligned;
   end

   // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q      <= 1'b0;
         out_link_q       <= '0;
         out_misaligned_q <= 1'b0;
         redirect_q       <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_q <= 1'b0;
         if (resolve) begin
            out_valid_q      <= 1'b1;
            out_link_q       <= link;
            out_misaligned_q <= misaligned;
            redirect_q       <= redirect_d;
            redirect_pc_q    <= target;
         end else if (br.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign br.out_valid      = out_valid_q;
   assign br.out_link       = out_link_q;
   assign br.out_misaligned = out_misaligned_q;
   assign br.redirect       = redirect_q;
   assign br.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_RESOLVE_BHT_EN
   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] upd_idx;
   logic             unused_lookup;

   assign upd_idx = br.in_pc[2 +: IDX_W];

   // NOTE: the table is a small flop array, so it is reset (weakly not-taken) rather than left as RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) bht[i] <= 2'b01;
      end else if (resolve && br.in_kind == KIND_BR) begin
         if (br.cmp_result && bht[upd_idx] != 2'b11)
            bht[upd_idx] <= bht[upd_idx] + 2'b01;
         else if (!br.cmp_result && bht[upd_idx] != 2'b00)
            bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
   end

   // Reading the flop array directly gives old-value semantics on a same-cycle update.
   assign br.lookup_taken = bht[br.lookup_pc[2 +: IDX_W]][1];
   assign unused_lookup   = ^br.lookup_pc;
`else
   logic unused_lookup;

   assign br.lookup_taken = 1'b0;
   assign unused_lookup   = (^br.lookup_pc) ^ (BHT_ENTRIES == 0);
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve. The BHT steps run only when BRANCH_RESOLVE_BHT_EN is defined.
module tb_branch_resolve;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   branch_resolve_if bif ();

   branch_resolve #(.BHT_ENTRIES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .br    (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic pred, input logic cmp);
      bif.in_valid      = 1'b1;
      bif.in_kind       = kind;
      bif.in_pc         = pc;
      bif.in_imm        = imm;
      bif.in_rs1        = rs1;
      bif.in_pred_taken = pred;
      bif.cmp_result    = cmp;
   endtask

   task automatic idle();
      bif.in_valid = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      bif.in_valid      = 1'b0;
      bif.in_pc         = '0;
      bif.in_imm        = '0;
      bif.in_rs1        = '0;
      bif.in_kind       = 2'b00;
      bif.in_pred_taken = 1'b0;
      bif.cmp_result    = 1'b0;
      bif.out_ready     = 1'b1;
      bif.lookup_pc     = 32'h40;
      step();
      step();

      check("rst_out_valid", bif.out_valid, 0);
      check("rst_out_link", bif.out_link, 0);
      check("rst_misaligned", bif.out_misaligned, 0);
      check("rst_redirect", bif.redirect, 0);
      check("rst_redirect_pc", bif.redirect_pc, 0);
      check("rst_in_ready", bif.in_ready, 1);
      check("rst_lookup_40", bif.lookup_taken, 0);
      bif.lookup_pc = 32'h44;
      #1;
      check("rst_lookup_44", bif.lookup_taken, 0);
      bif.lookup_pc = 32'h40;
      reset = 1'b1;

      // Taken branch predicted not-taken, followed by a wrong-path beat in the redirect cycle.
      drive(2'b01, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1);
      step();
      check("mp_out_valid", bif.out_valid, 1);
      check("mp_redirect", bif.redirect, 1);
      check("mp_redirect_pc", bif.redirect_pc, 32'h120);
      check("mp_link", bif.out_link, 32'h104);
      check("mp_in_ready", bif.in_ready, 1);
      drive(2'b10, 32'h300, 32'h40, 32'h0, 1'b0, 1'b0);
      step();
      check("sq_out_valid", bif.out_valid, 0);
      check("sq_redirect", bif.redirect, 0);
      check("sq_redirect_pc_held", bif.redirect_pc, 32'h120);

      // Correct prediction, then not-taken predicted taken.
      drive(2'b01, 32'h100, 32'h20, 32'h0, 1'b1, 1'b1);
      step();
      check("ok_out_valid", bif.out_valid, 1);
      check("ok_redirect", bif.redirect, 0);
      check("ok_link", bif.out_link, 32'h104);
      drive(2'b01, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0);
      step();
      check("nt_redirect", bif.redirect, 1);
      check("nt_redirect_pc", bif.redirect_pc, 32'h104);
      idle();
      step();
      check("nt_drain_valid", bif.out_valid, 0);
      check("nt_redirect_once", bif.redirect, 0);

      // jalr clears bit 0; jal to a half-word target is misaligned and suppresses redirect.
      drive(2'b11, 32'h500, 32'h0, 32'h2001, 1'b0, 1'b0);
      step();
      check("jalr_redirect", bif.redirect, 1);
      check("jalr_redirect_pc", bif.redirect_pc, 32'h2000);
      check("jalr_misaligned", bif.out_misaligned, 0);
      check("jalr_link", bif.out_link, 32'h504);
      idle();
      step();
      drive(2'b10, 32'h100, 32'h2, 32'h0, 1'b0, 1'b0);
      step();
      check("jal_mis_valid", bif.out_valid, 1);
      check("jal_mis_flag", bif.out_misaligned, 1);
      check("jal_mis_redirect", bif.redirect, 0);
      drive(2'b00, 32'h600, 32'h44, 32'h0, 1'b1, 1'b1);
      step();
      check("none_valid", bif.out_valid, 1);
      check("none_redirect", bif.redirect, 0);
      check("none_misaligned", bif.out_misaligned, 0);
      check("none_link", bif.out_link, 32'h604);

      // Mispredict followed by a three-cycle downstream stall.
      drive(2'b01, 32'h700, 32'h10, 32'h0, 1'b0, 1'b1);
      step();
      check("st1_redirect", bif.redirect, 1);
      check("st1_redirect_pc", bif.redirect_pc, 32'h710);
      check("st1_in_ready", bif.in_ready, 1);
      idle();
      bif.out_ready = 1'b0;
      step();
      check("st2_redirect", bif.redirect, 0);
      check("st2_out_valid", bif.out_valid, 1);
      check("st2_link", bif.out_link, 32'h704);
      check("st2_in_ready", bif.in_ready, 0);
      drive(2'b10, 32'h900, 32'h8, 32'h0, 1'b0, 1'b0);
      step();
      check("st3_redirect", bif.redirect, 0);
      check("st3_out_valid", bif.out_valid, 1);
      check("st3_link", bif.out_link, 32'h704);
      check("st3_redirect_pc", bif.redirect_pc, 32'h710);
      check("st3_in_ready", bif.in_ready, 0);
      bif.out_ready = 1'b1;
      step();
      check("st_rel_redirect", bif.redirect, 1);
      check("st_rel_redirect_pc", bif.redirect_pc, 32'h908);
      check("st_rel_link", bif.out_link, 32'h904);
      idle();
      step();
      check("st_rel_drain", bif.out_valid, 0);

      // Asynchronous reset while a beat is held.
      bif.out_ready = 1'b0;
      drive(2'b00, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      idle();
      step();
      check("ar_held_valid", bif.out_valid, 1);
      check("ar_held_link", bif.out_link, 32'h14);
      #2;
      reset = 1'b0;
      #1;
      check("ar_out_valid", bif.out_valid, 0);
      check("ar_out_link", bif.out_link, 0);
      reset = 1'b1;
      bif.out_ready = 1'b1;
      step();

      // Address wrap-around.
      drive(2'b01, 32'hFFFF_FFFC, 32'h40, 32'h0, 1'b1, 1'b0);
      step();
      check("wrap_redirect", bif.redirect, 1);
      check("wrap_redirect_pc", bif.redirect_pc, 32'h0);
      check("wrap_link", bif.out_link, 32'h0);
      idle();
      step();

`ifdef BRANCH_RESOLVE_BHT_EN
      bif.lookup_pc = 32'h40;
      #1;
      check("bht_init", bif.lookup_taken, 0);
      drive(2'b01, 32'h40, 32'h10, 32'h0, 1'b1, 1'b1);
      check("bht_old_value", bif.lookup_taken, 0);
      step();
      check("bht_t1", bif.lookup_taken, 1);
      step();
      check("bht_t2", bif.lookup_taken, 1);
      drive(2'b01, 32'h40, 32'h10, 32'h0, 1'b0, 1'b0);
      step();
      check("bht_n1", bif.lookup_taken, 1);
      step();
      check("bht_n2", bif.lookup_taken, 0);
      step();
      check("bht_n3", bif.lookup_taken, 0);
      step();
      idle();
      step();
      check("bht_sat0", bif.lookup_taken, 0);
      drive(2'b01, 32'h40, 32'h10, 32'h0, 1'b1, 1'b1);
      step();
      idle();
      check("bht_after_sat", bif.lookup_taken, 0);
      bif.lookup_pc = 32'h44;
      #1;
      check("bht_other_idx", bif.lookup_taken, 0);
`else
      bif.lookup_pc = 32'h40;
      #1;
      check("nobht_lookup", bif.lookup_taken, 0);
`endif

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
